// File: rtl/subtree_rr_scheduler_pkg.sv
// Shared types and helpers for the root-level subtree schedulers.
// Holds the FSM encoding, default sizing and a reference round-robin pick.
package subtree_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_e;

    localparam int DEF_NUM_REQ  = 5;
    localparam int DEF_MAX_HOLD = 16;
    localparam int PICK_MAX     = 16;

    // Scalar round-robin search over up to PICK_MAX requesters; returns {found, idx}.
    function automatic logic [4:0] rr_pick(input logic [PICK_MAX-1:0] req,
                                           input logic [3:0] ptr,
                                           input int num);
        logic       found;
        logic [3:0] idx;
        int         cand;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < PICK_MAX; i++) begin
            cand = int'(ptr) + i;
            if (cand >= num) begin
                cand = cand - num;
            end
            if ((i < num) && !found && req[cand[3:0]]) begin
                found = 1'b1;
                idx   = cand[3:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/subtree_rr_scheduler_rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// find the lowest set bit, then rotate the index back.
module rr_priority_pick
    import subtree_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    localparam logic [IDX_W:0] NUM_L = NUM_REQ[IDX_W:0];

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] shifted;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       sum;

    always_comb begin
        dbl     = {req_i, req_i};
        shifted = dbl >> ptr_i;
        rot     = shifted[NUM_REQ-1:0];
        found_o = |rot;
        offset  = '0;
        // Descending scan so the lowest set bit is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= NUM_L) begin
            sum = sum - NUM_L;
        end
        idx_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/subtree_rr_scheduler.sv
// Round-robin owner of one shared resource among the sibling leaves of a root node.
// Grants hold while requested, capped at MAX_HOLD cycles, with one dead cycle between grants.
module subtree_rr_scheduler
    import subtree_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               timeout_o,
    output logic               busy_o
);

    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    sched_state_e       state_q,   state_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic               valid_q,   valid_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [IDX_W-1:0]   ptr_q,     ptr_d;
    logic [CNT_W-1:0]   hold_q,    hold_d;
    logic               timeout_q, timeout_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             rel_normal;
    logic             rel_forced;
    logic [IDX_W-1:0] ptr_next;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        rel_normal = !req_i[idx_q];
        rel_forced = (hold_q == HOLD_MAX);
        ptr_next   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                state_d = ST_IDLE;
                if (en_i && pick_found) begin
                    state_d           = ST_GRANT;
                    grant_d[pick_idx] = 1'b1;
                    valid_d           = 1'b1;
                    idx_d             = pick_idx;
                    hold_d            = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                // A requester dropping on the cap cycle is a normal release, not a timeout.
                if (rel_normal || rel_forced) begin
                    state_d   = ST_GAP;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = ptr_next;
                    timeout_d = !rel_normal;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        grant_o       = grant_q;
        grant_valid_o = valid_q;
        grant_idx_o   = idx_q;
        timeout_o     = timeout_q;
        busy_o        = (state_q != ST_IDLE);
    end

endmodule
